// File: rtl/pin_bus_pkg.sv
// Shared types and constants for the device pin bus arbiter.
// SYNC_DEPTH is only used when PIN_SYNC_EN is defined.
package pin_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int PIN_W      = 29;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// The search starts at ptr and wraps modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] win,
    output logic            any_req
);

    logic            found;
    logic [PTRW-1:0] idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTRW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pin_bus_arbiter.sv
// Round-robin owner of the shared device pin bus with a turnaround cycle.
// Define PIN_SYNC_EN to sample pin_in through a 2-flop synchronizer.
module pin_bus_arbiter
    import pin_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = PIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  is_write,
    input  logic [NREQ*PW-1:0] wdata,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic [PW-1:0]    rdata,
    output logic             rparity,
    output logic [PW-1:0]    pin_out,
    output logic [PW-1:0]    pin_oe,
    input  logic [PW-1:0]    pin_in
);

    localparam int PTRW = $clog2(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [PTRW-1:0] ptr;
    logic [PTRW-1:0] ptr_nxt;
    logic [PTRW-1:0] win_idx;
    logic [NREQ-1:0] win;
    logic            any_req;
    logic            wr;
    logic            win_wr;
    logic            xfer_last;
    logic [PW-1:0]   wsel;
    logic [PW-1:0]   sample;

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .any_req (any_req)
    );

    always_comb begin
        win_idx = '0;
        wsel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PTRW'(i);
                wsel    = wdata[i*PW +: PW];
            end
        end
    end

    assign win_wr  = |(is_write & win);
    assign ptr_nxt = (win_idx == PTRW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef PIN_SYNC_EN
    logic [PW-1:0] sync_q [SYNC_DEPTH];
    logic [1:0]    cnt;

    // Reads stay in XFER until the synchronizer has flushed the pin value.
    assign xfer_last = wr || (cnt == 2'(SYNC_DEPTH));
    assign sample    = sync_q[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
            cnt <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
            cnt <= (state == XFER && !xfer_last) ? cnt + 1'b1 : '0;
        end
    end
`else
    assign xfer_last = 1'b1;
    assign sample    = pin_in;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = XFER;
            XFER:    if (xfer_last) state_nxt = TURN;
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            wr      <= 1'b0;
            pin_out <= '0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= win;
                        wr    <= win_wr;
                        ptr   <= ptr_nxt;
                        if (win_wr) pin_out <= wsel;
                    end
                end
                XFER:    if (xfer_last && !wr) rdata <= sample;
                TURN:    grant <= '0;
                default: ;
            endcase
        end
    end

    // Decoded from state so an async reset releases the pins at once.
    assign pin_oe  = {PW{(state == XFER) && wr}};
    assign done    = (state == TURN) ? grant : '0;
    assign rparity = ^rdata;

endmodule

// File: tb/tb_pin_bus_arbiter.sv
// Self-checking bench for pin_bus_arbiter.
// Transaction-level model: winner search, latched data, read capture.
module tb_pin_bus_arbiter;

    localparam int N = 4;
    localparam int W = 29;
`ifdef PIN_SYNC_EN
    localparam int RDX = 3;
`else
    localparam int RDX = 1;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   is_write;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   rdata;
    logic           rparity;
    logic [W-1:0]   pin_out;
    logic [W-1:0]   pin_oe;
    logic [W-1:0]   pin_in;

    int           total = 0;
    int           bad   = 0;
    int           mptr  = 0;
    logic [W-1:0] mrdata = '0;
    logic         prev_oe = 1'b0;

    always #5 clk = ~clk;

    pin_bus_arbiter #(.NREQ(N), .PW(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .is_write (is_write),
        .wdata    (wdata),
        .grant    (grant),
        .done     (done),
        .rdata    (rdata),
        .rparity  (rparity),
        .pin_out  (pin_out),
        .pin_oe   (pin_oe),
        .pin_in   (pin_in)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            total++;
            if ((prev_oe && |pin_oe) || (pin_oe !== '0 && pin_oe !== '1)) begin
                bad++;
                $display("FAIL oe_rule got=%h prev_high=%0b", pin_oe, prev_oe);
            end
        end
        prev_oe = |pin_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1);
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mptr   = 0;
        mrdata = '0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        total++;
        if (grant !== '0 || done !== '0 || pin_oe !== '0) begin
            bad++;
            $display("FAIL idle got=%b/%b/%h need=0", grant, done, pin_oe);
        end
    endtask

    // Entered at the negedge of an IDLE cycle with req already driven.
    task automatic run_txn(input bit drop, input bit mutate,
                           output logic [N-1:0] g);
        int           w;
        logic         wr;
        logic [W-1:0] d;
        logic [W-1:0] pin;
        logic [N-1:0] oh;
        w     = pick(req, mptr);
        oh    = '0;
        oh[w] = 1'b1;
        wr    = is_write[w];
        d     = wdata[w*W +: W];
        pin   = pin_in;
        mptr  = (w + 1) % N;
        @(posedge clk);
        #1;
        g = grant;
        if (mutate) begin
            wdata[w*W +: W] = ~d;
            is_write[w]     = ~wr;
        end
        for (int c = 0; c < (wr ? 1 : RDX); c++) begin
            @(negedge clk);
            total++;
            if (grant !== oh || done !== '0) begin
                bad++;
                $display("FAIL xfer_grant got=%b/%b need=%b/0", grant, done, oh);
            end
            total++;
            if (pin_oe !== {W{wr}}) begin
                bad++;
                $display("FAIL xfer_oe got=%h need=%h", pin_oe, {W{wr}});
            end
            if (wr) begin
                total++;
                if (pin_out !== d) begin
                    bad++;
                    $display("FAIL xfer_data got=%h need=%h", pin_out, d);
                end
            end
        end
        @(negedge clk);
        if (!wr) mrdata = pin;
        total++;
        if (grant !== oh || done !== oh) begin
            bad++;
            $display("FAIL turn_done got=%b/%b need=%b/%b", grant, done, oh, oh);
        end
        total++;
        if (pin_oe !== '0) begin
            bad++;
            $display("FAIL turn_oe got=%h need=0", pin_oe);
        end
        total++;
        if (rdata !== mrdata || rparity !== ^mrdata) begin
            bad++;
            $display("FAIL rdata got=%h/%0b need=%h/%0b",
                     rdata, rparity, mrdata, ^mrdata);
        end
        if (wr) begin
            total++;
            if (pin_out !== d) begin
                bad++;
                $display("FAIL turn_hold got=%h need=%h", pin_out, d);
            end
        end
        if (drop) req[w] = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] g;
        rst_n    = 1'b0;
        req      = '1;
        is_write = '0;
        wdata    = '0;
        pin_in   = '1;
        repeat (3) @(negedge clk);
        total++;
        if (grant !== '0 || done !== '0 || pin_oe !== '0) begin
            bad++;
            $display("FAIL reset_ctl got=%b/%b/%h need=0", grant, done, pin_oe);
        end
        total++;
        if (rdata !== '0 || rparity !== 1'b0 || pin_out !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h/%0b/%h need=0", rdata, rparity, pin_out);
        end
        rst_n  = 1'b1;
        mptr   = 0;
        mrdata = '0;
        pin_in = '0;
        req    = 4'b0001;
        is_write = 4'b0001;
        wdata[0 +: W] = 29'h155_5555;
        run_txn(1'b1, 1'b0, g);
        idle_check();
    endtask

    task automatic test_read();
        logic [N-1:0] g;
        req         = 4'b0100;
        is_write[2] = 1'b0;
        pin_in      = 29'h0000_0007;
        run_txn(1'b1, 1'b0, g);
        total++;
        if (rdata !== 29'h7 || rparity !== 1'b1) begin
            bad++;
            $display("FAIL read7 got=%h/%0b need=7/1", rdata, rparity);
        end
        idle_check();
    endtask

    task automatic test_fairness();
        logic [N-1:0] g;
        int           order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req = '1;
        for (int i = 0; i < 5; i++) begin
            is_write = N'($urandom);
            for (int j = 0; j < N; j++) wdata[j*W +: W] = W'($urandom);
            pin_in = W'($urandom);
            run_txn(1'b0, 1'b0, g);
            total++;
            if (g !== N'(1) << order[i]) begin
                bad++;
                $display("FAIL fair_order got=%b need=%0d", g, order[i]);
            end
            idle_check();
        end
        req = '0;
    endtask

    task automatic test_wrap();
        logic [N-1:0] g;
        apply_reset();
        req      = 4'b0100;
        is_write = '1;
        run_txn(1'b1, 1'b0, g);
        idle_check();
        req = 4'b1010;
        run_txn(1'b1, 1'b0, g);
        total++;
        if (g !== 4'b1000) begin
            bad++;
            $display("FAIL wrap_first got=%b need=1000", g);
        end
        idle_check();
        run_txn(1'b1, 1'b0, g);
        total++;
        if (g !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_second got=%b need=0010", g);
        end
        idle_check();
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] g;
        req      = 4'b0010;
        is_write = '1;
        wdata[W +: W] = W'($urandom);
        @(posedge clk);
        #1;
        total++;
        if (grant !== 4'b0010 || pin_oe !== '1) begin
            bad++;
            $display("FAIL mid_pre got=%b/%h need=0010/all1", grant, pin_oe);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (pin_oe !== '0 || grant !== '0 || done !== '0) begin
            bad++;
            $display("FAIL mid_abort got=%h/%b/%b need=0", pin_oe, grant, done);
        end
        req = '0;
        @(negedge clk);
        total++;
        if (done !== '0) begin
            bad++;
            $display("FAIL mid_done got=%b need=0", done);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mptr   = 0;
        mrdata = '0;
        req    = 4'b0011;
        run_txn(1'b1, 1'b0, g);
        total++;
        if (g !== 4'b0001) begin
            bad++;
            $display("FAIL mid_next got=%b need=0001", g);
        end
        idle_check();
        req = '0;
        idle_check();
    endtask

    task automatic test_data_hold();
        logic [N-1:0] g;
        logic [W-1:0] rd;
        req         = 4'b1000;
        is_write[3] = 1'b0;
        rd          = W'($urandom) | 29'h1;
        pin_in      = rd;
        run_txn(1'b1, 1'b0, g);
        idle_check();
        req         = 4'b0010;
        is_write[1] = 1'b1;
        wdata[W +: W] = W'($urandom);
        pin_in      = ~rd;
        run_txn(1'b1, 1'b1, g);
        total++;
        if (rdata !== rd) begin
            bad++;
            $display("FAIL hold_rdata got=%h need=%h", rdata, rd);
        end
        idle_check();
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        for (int it = 0; it < 40; it++) begin
            is_write = N'($urandom);
            for (int j = 0; j < N; j++) wdata[j*W +: W] = W'($urandom);
            pin_in = W'($urandom);
            req    = req | N'($urandom);
            if (req == '0) begin
                idle_check();
            end else begin
                run_txn(($urandom % 4) != 0, 1'b0, g);
                idle_check();
            end
        end
        req = '0;
        idle_check();
    endtask

    initial begin
        test_reset();
        test_read();
        test_fairness();
        test_wrap();
        test_mid_reset();
        test_data_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
